// File: rtl/adc_serial_capture_if.sv
// Bus bundle for adc_serial_capture: trigger/ADC-facing inputs and capture outputs.
// The slave modport is the capture block; the master modport is its environment.
interface adc_serial_capture_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 1
) ();
    logic                     en;
    logic                     start;
    logic [NUM_CH-1:0]        dout;
    logic                     convst;
    logic                     sclk;
    logic                     busy;
    logic                     overrun;
    logic                     outvalid;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        clip;

    modport master (
        output en, start, dout,
        input  convst, sclk, busy, overrun, outvalid, data, clip
    );

    modport slave (
        input  en, start, dout,
        output convst, sclk, busy, overrun, outvalid, data, clip
    );
endinterface

// File: rtl/adc_serial_capture.sv
// Multi-lane serial ADC capture: CONVST pulse, divided SCLK, MSB-first shift, valid strobe.
// Optional macro ADC_CLIP_REJECT_EN: words at full-scale min/max keep the old value and pulse clip.
module adc_serial_capture #(
    parameter int DATA_W   = 16,
    parameter int NUM_CH   = 1,
    parameter int SCLK_DIV = 1,
    parameter int CONV_CYC = 45
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_serial_capture_if.slave  bus
);
    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNV_W = $clog2(CONV_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(CONV_CYC);

`ifdef ADC_CLIP_REJECT_EN
    function automatic logic is_clip(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] min_w;
        min_w   = {1'b1, {(DATA_W-1){1'b0}}};
        is_clip = (w == min_w) || (w == ~min_w);
    endfunction
`endif

    logic [1:0]                          state_q, state_d;
    logic [CNV_W-1:0]                    conv_cnt_q, conv_cnt_d;
    logic [DIV_W-1:0]                    div_q, div_d;
    logic [BIT_W-1:0]                    bit_q, bit_d;
    logic                                sclk_q, sclk_d;
    logic                                convst_q, convst_d;
    logic                                busy_q, busy_d;
    logic                                overrun_q, overrun_d;
    logic                                outvalid_q, outvalid_d;
    logic [NUM_CH*DATA_W-1:0]            data_q, data_d;
    logic [NUM_CH-1:0]                   clip_q, clip_d;
    // The last bit of a word comes straight from dout, so only DATA_W-1 bits are stored.
    logic [NUM_CH-1:0][DATA_W-2:0]       shift_q, shift_d;
    logic [NUM_CH-1:0][DATA_W-1:0]       capt_s;
    logic                                accept_s;
    logic                                frame_end_s;

    assign accept_s    = bus.en & bus.start;
    assign frame_end_s = (state_q == ST_SHIFT) && (div_q == DIV_LAST) && sclk_q
                         && (bit_q == {BIT_W{1'b0}});

    // Word as it would look after shifting in the current dout sample.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            capt_s[i] = {shift_q[i], bus.dout[i]};
        end
    end

    // Next-state logic for the conversion/shift sequencer.
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        convst_d   = convst_q;
        shift_d    = shift_q;
        data_d     = data_q;
        outvalid_d = 1'b0;
        clip_d     = {NUM_CH{1'b0}};
        overrun_d  = accept_s && (state_q != ST_IDLE) && !frame_end_s;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_CONV;
                    convst_d   = 1'b1;
                    conv_cnt_d = CNV_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_cnt_q == CNV_LAST) begin
                    state_d  = ST_SHIFT;
                    convst_d = 1'b0;
                    bit_d    = BIT_LAST;
                    div_d    = {DIV_W{1'b0}};
                    sclk_d   = 1'b0;
                end else begin
                    conv_cnt_d = conv_cnt_q + CNV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else if (!sclk_q) begin
                    div_d  = {DIV_W{1'b0}};
                    sclk_d = 1'b1;
                end else begin
                    // SCLK falling edge: sample the bit the ADC has held for the whole period.
                    div_d  = {DIV_W{1'b0}};
                    sclk_d = 1'b0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        shift_d[i] = capt_s[i][DATA_W-2:0];
                    end
                    if (bit_q != {BIT_W{1'b0}}) begin
                        bit_d = bit_q - BIT_W'(1);
                    end else begin
                        outvalid_d = 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
`ifdef ADC_CLIP_REJECT_EN
                            if (is_clip(capt_s[i])) begin
                                clip_d[i] = 1'b1;
                            end else begin
                                data_d[i*DATA_W +: DATA_W] = capt_s[i];
                            end
`else
                            data_d[i*DATA_W +: DATA_W] = capt_s[i];
`endif
                        end
                        if (accept_s) begin
                            state_d    = ST_CONV;
                            convst_d   = 1'b1;
                            conv_cnt_d = CNV_W'(1);
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                convst_d = 1'b0;
                sclk_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= {CNV_W{1'b0}};
            div_q      <= {DIV_W{1'b0}};
            bit_q      <= {BIT_W{1'b0}};
            sclk_q     <= 1'b0;
            convst_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            outvalid_q <= 1'b0;
            data_q     <= {(NUM_CH*DATA_W){1'b0}};
            clip_q     <= {NUM_CH{1'b0}};
            shift_q    <= {(NUM_CH*(DATA_W-1)){1'b0}};
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            convst_q   <= convst_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            outvalid_q <= outvalid_d;
            data_q     <= data_d;
            clip_q     <= clip_d;
            shift_q    <= shift_d;
        end
    end

    assign bus.convst   = convst_q;
    assign bus.sclk     = sclk_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
    assign bus.outvalid = outvalid_q;
    assign bus.data     = data_q;
    assign bus.clip     = clip_q;
endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
- Parametrised successor to the team's single-channel 16-bit serial ADC reader.
- Generates its own CONVST pulse and a divided, free-running-clock-derived SCLK; no gated clock.
- Shifts NUM_CH parallel DOUT lanes of DATA_W bits each and presents the words with a one-cycle valid strobe.
- Sits between the sample-rate trigger logic and the acquisition buffer of the oscilloscope front end.

Parameters:
- DATA_W, 16: bits per conversion word; 8 to 32.
- NUM_CH, 1: number of parallel ADC DOUT lanes sharing CONVST and SCLK; at least 1.
- SCLK_DIV, 1: SCLK half-period in clk cycles; at least 1.
- CONV_CYC, 45: CONVST high time in clk cycles (conversion time); at least 1.

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  synchronous reset, active-low, sampled on rising clk
- en  in  1  enables acceptance of start
- start  in  1  conversion request, level-sampled
- dout  in  NUM_CH  serial data lanes, lane i drives channel i
- convst  out  1  conversion start to the ADCs
- sclk  out  1  serial clock to the ADCs, registered
- busy  out  1  high while a frame is in progress
- overrun  out  1  one-cycle pulse when start is rejected
- outvalid  out  1  one-cycle pulse when data is updated
- data  out  NUM_CH*DATA_W  channel i is at [i*DATA_W +: DATA_W], MSB first
- clip  out  NUM_CH  per-channel clip-reject pulse, aligned with outvalid

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE.
  - convst, sclk, busy, overrun, outvalid, clip all 0.
  - data cleared to 0.
  - Reset mid-frame aborts immediately; no outvalid is produced.
- States: IDLE, CONV, SHIFT. busy = (state != IDLE).
- IDLE:
  - If en=1 and start=1 at edge T: state becomes CONV and convst=1 from T.
  - Otherwise hold.
- CONV:
  - convst stays high for exactly CONV_CYC cycles.
  - At edge T+CONV_CYC: convst=0, state becomes SHIFT, bit counter=DATA_W-1, div counter=0, sclk=0.
- SHIFT: each bit period is 2*SCLK_DIV cycles.
  - sclk is low for the first SCLK_DIV cycles and high for the next SCLK_DIV.
  - At the edge ending each bit period (the sclk high-to-low transition), dout[i] is shifted into shift register i, MSB first.
  - The ADC launches the MSB on CONVST falling and each following bit on SCLK falling, so the sample point is the pre-fall value.
  - Exactly DATA_W SCLK pulses per frame.
- Frame end, at edge T+CONV_CYC+2*SCLK_DIV*DATA_W:
  - data is loaded from the shift registers.
  - outvalid=1 for one cycle.
  - state becomes IDLE, busy=0.
  - A start present in that outvalid cycle is accepted, giving back-to-back frames with no idle gap.
- Overrun and en:
  - start=1 while busy=1 (with en=1) gives overrun=1 for that cycle; the request is dropped and the frame is unaffected.
  - A held-high start produces one overrun pulse per busy cycle.
  - en=0 blocks new starts only; a frame in progress completes normally.
- data holds its value between frames. Shift registers are not visible externally.
- Widths:
  - Div counter is clog2(SCLK_DIV+1) bits.
  - Bit counter is clog2(DATA_W) bits.
  - CONV counter is clog2(CONV_CYC+1) bits.
  - No wrap beyond terminal counts.

Optional Feature:
- Macro: ADC_CLIP_REJECT_EN.
- Defined:
  - At frame end, a channel whose captured word equals the two's-complement minimum (1 followed by 0s) or maximum (0 followed by 1s) keeps its previous data value.
  - That channel's clip bit pulses with outvalid.
  - Other channels update normally; outvalid still pulses.
- Not defined: every channel always updates, and clip is tied to 0.

Test Plan (DATA_W=16, NUM_CH=2, SCLK_DIV=2, CONV_CYC=4 unless noted):
- Basic frame:
  - Stimulus: start pulse at edge 0; ADC model drives lane0=0x1234, lane1=0xBEEF.
  - Required: convst high at cycles 0-3; 16 sclk pulses of 4 cycles each over cycles 4-67; outvalid only at cycle 68; data=0xBEEF_1234.
- Back-to-back:
  - Stimulus: start held high continuously.
  - Required: a new frame begins in every outvalid cycle; frame period 68 cycles; overrun pulses in every busy cycle.
- Mid-frame behaviour:
  - Stimulus: start pulse at cycle 20 during SHIFT.
  - Required: overrun=1 at cycle 20 only; the frame completes unchanged.
  - Stimulus: en dropped at cycle 10.
  - Required: the frame still completes, and later starts are ignored with no overrun.
- Reset mid-frame:
  - Stimulus: rst=0 at cycle 30.
  - Required: next cycle has convst=sclk=busy=0 and data=0; no outvalid until a new start.
- Clip reject (ADC_CLIP_REJECT_EN defined, after data=0x0001_0002):
  - Stimulus: lane0=0x8000, lane1=0x7FFF.
  - Required: data unchanged, clip=2'b11.
  - Stimulus: lane0=0x8000, lane1=0x0100.
  - Required: data=0x0100_0002, clip=2'b01.
  - Without the macro: data=0x0100_8000, clip=0.
- Corner parameters:
  - SCLK_DIV=1, DATA_W=18, NUM_CH=1, CONV_CYC=1.
  - Required: 18 sclk pulses each 2 cycles long; outvalid at cycle 37; walking-ones patterns are captured exactly.
